// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder with sub-word reads/writes and little-endian lanes.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            trunk_mode,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           in_data,
  output logic [31:0]           out_data,
  output logic                  resp_valid,
  output logic                  misaligned
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            mode_q;
  logic [31:0]           wdata_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [31:0]           rmw_q;
  logic [31:0]           out_q;
  logic                  respv_q;

  logic [31:0] mem [0:WORDS-1];

  logic                  accept;
  logic                  trapReq;
  logic                  inHalf, inWord;
  logic                  isByte, isHalf;
  logic [1:0]            laneOff;
  logic [4:0]            shAmt;
  logic [ADDR_WIDTH-3:0] wordIdx;
  logic [31:0]           rdWord, rdShift, rdExt;
  logic [31:0]           laneMask, mergeWord;

  assign accept  = req_valid && (state_q == IDLE);
  assign inHalf  = (trunk_mode == 3'd1) || (trunk_mode == 3'd2);
  assign inWord  = !(inHalf || (trunk_mode == 3'd3) || (trunk_mode == 3'd4));
  assign isHalf  = (mode_q == 3'd1) || (mode_q == 3'd2);
  assign isByte  = (mode_q == 3'd3) || (mode_q == 3'd4);
  assign wordIdx = addr_q[ADDR_WIDTH-1:2];

`ifdef MISALIGN_TRAP_EN
  logic misal_q;
  assign trapReq    = accept && (MemRead || MemWrite) &&
                      ((inHalf && address[0]) || (inWord && (address[1:0] != 2'b00)));
  assign misaligned = misal_q;
`else
  assign trapReq    = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = respv_q;
  assign out_data   = out_q;

  // Offending low address bits are dropped so accesses fall on their natural boundary.
  always_comb begin
    laneOff = 2'b00;
    if (isByte)      laneOff = addr_q[1:0];
    else if (isHalf) laneOff = {addr_q[1], 1'b0};
    shAmt = {laneOff, 3'b000};
  end

  always_comb begin
    rdWord  = mem[wordIdx];
    rdShift = rdWord >> shAmt;
    case (mode_q)
      3'd1:    rdExt = {16'h0000, rdShift[15:0]};
      3'd2:    rdExt = {{16{rdShift[15]}}, rdShift[15:0]};
      3'd3:    rdExt = {24'h000000, rdShift[7:0]};
      3'd4:    rdExt = {{24{rdShift[7]}}, rdShift[7:0]};
      default: rdExt = rdWord;
    endcase
  end

  always_comb begin
    laneMask = 32'hFFFF_FFFF;
    if (isByte)      laneMask = 32'h0000_00FF << shAmt;
    else if (isHalf) laneMask = 32'h0000_FFFF << shAmt;
    mergeWord = (rmw_q & ~laneMask) | ((wdata_q << shAmt) & laneMask);
  end

  // A simultaneous read+write request is routed down the write path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (trapReq)       state_d = RESP;
          else if (MemWrite) state_d = inWord ? WR : RMW_RD;
          else if (MemRead)  state_d = RD;
          else               state_d = RESP;
        end
      end
      RD:      state_d = RESP;
      WR:      state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mode_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rmw_q   <= '0;
      out_q   <= '0;
      respv_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      respv_q <= (state_d == RESP);
      if (accept) begin
        addr_q  <= address;
        mode_q  <= trunk_mode;
        wdata_q <= in_data;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
      end
      if (state_q == RD && rd_q) out_q <= rdExt;
      if (state_q == RMW_RD)     rmw_q <= rdWord;
`ifdef MISALIGN_TRAP_EN
      if (accept) misal_q <= trapReq;
      else if (state_q == RESP) misal_q <= 1'b0;
      if (trapReq) out_q <= '0;
`endif
    end
  end

  // Storage has no reset; a write lands only on the edge leaving WR or RMW_WR.
  always_ff @(posedge clock) begin
    if (state_q == WR && wr_q)  mem[wordIdx] <= wdata_q;
    else if (state_q == RMW_WR) mem[wordIdx] <= mergeWord;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: lanes, extension, latency, reset abort, misalignment.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  trunk_mode;
  logic [10:0] address;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        resp_valid;
  logic        misaligned;

  int testsRun;
  int testsFailed;

  data_mem_responder #(.ADDR_WIDTH(11)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .trunk_mode (trunk_mode),
    .address    (address),
    .in_data    (in_data),
    .out_data   (out_data),
    .resp_valid (resp_valid),
    .misaligned (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one request and reports latency (accept edge to resp_valid cycle), response
  // data/flag, and whether resp_valid was still high one cycle later.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] mode,
                               input logic [10:0] addr, input logic [31:0] data,
                               output int lat, output logic [31:0] rdata,
                               output logic mis, output logic after);
    int wait_cnt;
    @(negedge clock);
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 10) begin
      @(negedge clock);
      wait_cnt++;
    end
    req_valid  = 1'b1;
    MemRead    = rd;
    MemWrite   = wr;
    trunk_mode = mode;
    address    = addr;
    in_data    = data;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    rdata = out_data;
    mis   = misaligned;
    @(posedge clock);
    #1;
    after = resp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    testsRun++;
    if (req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready got=%b exp=1", req_ready);
    end
    testsRun++;
    if (resp_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    testsRun++;
    if (out_data !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out_data got=%h exp=00000000", out_data);
    end
    testsRun++;
    if (misaligned !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_misaligned got=%b exp=0", misaligned);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] d; logic m, a;
    applyStimulus(1'b0, 1'b1, 3'b000, 11'h010, 32'hDEADBEEF, lat, d, m, a);
    testsRun++;
    if (lat !== 2) begin
      testsFailed++;
      $display("[TB] FAIL word_write_latency got=%0d exp=2", lat);
    end
    testsRun++;
    if (a !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL resp_one_cycle got=%b exp=0", a);
    end
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h010, 32'h0, lat, d, m, a);
    testsRun++;
    if (lat !== 2) begin
      testsFailed++;
      $display("[TB] FAIL word_read_latency got=%0d exp=2", lat);
    end
    testsRun++;
    if (d !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL word_read_data got=%h exp=deadbeef", d);
    end
  endtask

  task automatic test_byte_rmw();
    int lat; logic [31:0] d; logic m, a;
    applyStimulus(1'b0, 1'b1, 3'b000, 11'h010, 32'h11223344, lat, d, m, a);
    applyStimulus(1'b0, 1'b1, 3'b011, 11'h013, 32'h000000A5, lat, d, m, a);
    testsRun++;
    if (lat !== 3) begin
      testsFailed++;
      $display("[TB] FAIL byte_write_latency got=%0d exp=3", lat);
    end
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h010, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'hA5223344) begin
      testsFailed++;
      $display("[TB] FAIL byte_merge got=%h exp=a5223344", d);
    end
    applyStimulus(1'b1, 1'b0, 3'b100, 11'h013, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'hFFFFFFA5) begin
      testsFailed++;
      $display("[TB] FAIL byte_sext got=%h exp=ffffffa5", d);
    end
    applyStimulus(1'b1, 1'b0, 3'b011, 11'h013, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'h000000A5) begin
      testsFailed++;
      $display("[TB] FAIL byte_zext got=%h exp=000000a5", d);
    end
    applyStimulus(1'b1, 1'b0, 3'b011, 11'h011, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'h00000033) begin
      testsFailed++;
      $display("[TB] FAIL byte_lane1 got=%h exp=00000033", d);
    end
  endtask

  task automatic test_half();
    int lat; logic [31:0] d; logic m, a;
    applyStimulus(1'b0, 1'b1, 3'b000, 11'h010, 32'h80017FFF, lat, d, m, a);
    applyStimulus(1'b1, 1'b0, 3'b010, 11'h012, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'hFFFF8001) begin
      testsFailed++;
      $display("[TB] FAIL half_sext got=%h exp=ffff8001", d);
    end
    applyStimulus(1'b1, 1'b0, 3'b001, 11'h010, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'h00007FFF) begin
      testsFailed++;
      $display("[TB] FAIL half_zext got=%h exp=00007fff", d);
    end
    applyStimulus(1'b0, 1'b1, 3'b001, 11'h012, 32'h1234BEEF, lat, d, m, a);
    testsRun++;
    if (lat !== 3) begin
      testsFailed++;
      $display("[TB] FAIL half_write_latency got=%0d exp=3", lat);
    end
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h010, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'hBEEF7FFF) begin
      testsFailed++;
      $display("[TB] FAIL half_merge got=%h exp=beef7fff", d);
    end
  endtask

  task automatic test_read_write_both();
    int lat; logic [31:0] d; logic m, a;
    applyStimulus(1'b1, 1'b1, 3'b000, 11'h020, 32'h12345678, lat, d, m, a);
    testsRun++;
    if (lat !== 2) begin
      testsFailed++;
      $display("[TB] FAIL both_latency got=%0d exp=2", lat);
    end
    testsRun++;
    if (d !== 32'hBEEF7FFF) begin
      testsFailed++;
      $display("[TB] FAIL both_out_hold got=%h exp=beef7fff", d);
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 11'h020, 32'h0, lat, d, m, a);
    testsRun++;
    if (lat !== 1) begin
      testsFailed++;
      $display("[TB] FAIL noop_latency got=%0d exp=1", lat);
    end
    testsRun++;
    if (d !== 32'hBEEF7FFF) begin
      testsFailed++;
      $display("[TB] FAIL noop_out_hold got=%h exp=beef7fff", d);
    end
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h020, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'h12345678) begin
      testsFailed++;
      $display("[TB] FAIL both_written got=%h exp=12345678", d);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] d; logic m, a;
    int pulses;
    applyStimulus(1'b0, 1'b1, 3'b000, 11'h030, 32'h0A0B0C0D, lat, d, m, a);
    @(negedge clock);
    req_valid  = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b1;
    trunk_mode = 3'b011;
    address    = 11'h031;
    in_data    = 32'h000000FF;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    testsRun++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || out_data !== 32'h0 || misaligned !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_outputs got=rdy%b rv%b od%h mis%b exp=rdy1 rv0 od00000000 mis0",
               req_ready, resp_valid, out_data, misaligned);
    end
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      if (resp_valid) pulses++;
    end
    testsRun++;
    if (pulses !== 0 || req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_resp got=pulses%0d rdy%b exp=pulses0 rdy1", pulses, req_ready);
    end
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h030, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'h0A0B0C0D) begin
      testsFailed++;
      $display("[TB] FAIL abort_mem_unchanged got=%h exp=0a0b0c0d", d);
    end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] d; logic m, a;
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h012, 32'h0, lat, d, m, a);
`ifdef MISALIGN_TRAP_EN
    testsRun++;
    if (lat !== 1 || m !== 1'b1 || d !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL misalign_trap got=lat%0d mis%b od%h exp=lat1 mis1 od00000000", lat, m, d);
    end
`else
    testsRun++;
    if (lat !== 2 || m !== 1'b0 || d !== 32'hBEEF7FFF) begin
      testsFailed++;
      $display("[TB] FAIL misalign_align got=lat%0d mis%b od%h exp=lat2 mis0 odbeef7fff", lat, m, d);
    end
`endif
  endtask

  task automatic test_top_index();
    int lat; logic [31:0] d; logic m, a;
    applyStimulus(1'b0, 1'b1, 3'b000, 11'h000, 32'h00000001, lat, d, m, a);
    applyStimulus(1'b0, 1'b1, 3'b000, 11'h7FC, 32'hCAFEF00D, lat, d, m, a);
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h7FC, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'hCAFEF00D) begin
      testsFailed++;
      $display("[TB] FAIL top_index got=%h exp=cafef00d", d);
    end
    applyStimulus(1'b1, 1'b0, 3'b000, 11'h000, 32'h0, lat, d, m, a);
    testsRun++;
    if (d !== 32'h00000001) begin
      testsFailed++;
      $display("[TB] FAIL no_wrap got=%h exp=00000001", d);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic prev;
    logic adjacent;
    @(negedge clock);
    req_valid  = 1'b1;
    MemRead    = 1'b1;
    MemWrite   = 1'b0;
    trunk_mode = 3'b000;
    address    = 11'h7FC;
    pulses     = 0;
    prev       = 1'b0;
    adjacent   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      if (resp_valid) pulses++;
      if (resp_valid && prev) adjacent = 1'b1;
      prev = resp_valid;
    end
    req_valid = 1'b0;
    testsRun++;
    if (pulses !== 3 || adjacent !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back got=pulses%0d adj%b exp=pulses3 adj0", pulses, adjacent);
    end
    testsRun++;
    if (out_data !== 32'hCAFEF00D) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_data got=%h exp=cafef00d", out_data);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    pulses = 0;
    if (resp_valid) pulses++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      if (resp_valid) pulses++;
    end
    testsRun++;
    if (pulses !== 1) begin
      testsFailed++;
      $display("[TB] FAIL busy_not_queued got=%0d exp=1", pulses);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    req_valid   = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    trunk_mode  = 3'b000;
    address     = '0;
    in_data     = '0;
    test_reset();
    test_word_rw();
    test_byte_rmw();
    test_half();
    test_read_write_both();
    test_reset_mid_op();
    test_misalign();
    test_top_index();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
